// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the register-file writeback arbiter.
//   DEPTH_DEF      : default number of LSU writeback FIFO entries
//   STARVE_MAX_DEF : default number of back-to-back ALU writes allowed
//                    while LSU results are waiting
//   wb_entry_t     : one pending register-file write (destination + data)
package wb_pkg;

  localparam int DEPTH_DEF      = 4;
  localparam int STARVE_MAX_DEF = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- synchronous in-order FIFO holding pending LSU writebacks.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write pushEntry_i at the tail (caller guarantees not full)
//   pushEntry_i  : entry to store
//   pop_i        : drop the head entry (caller guarantees not empty)
//   head_o       : current head entry, valid whenever count_o != 0
//   count_o      : current occupancy, 0..DEPTH
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wb_entry_t              pushEntry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW:0]     cnt_q, cnt_d;

  // Pointer and occupancy update. DEPTH is a power of two, so the
  // pointers wrap modulo DEPTH simply by overflowing their width.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (push_i) wrPtr_d = wrPtr_q + 1'b1;
    if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i && !rst) mem_q[wrPtr_q] <= pushEntry_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_arb.sv
// wb_arb -- merges single-cycle ALU results and buffered LSU results onto
// one register-file write port.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   alu_vld/alu_addr/alu_data       : ALU result; held stable while alu_stall
//   alu_stall                       : ALU result not accepted this cycle
//   lsu_vld/lsu_addr/lsu_data       : LSU result, accepted when lsu_rdy
//   lsu_rdy                         : FIFO has room for an LSU result
//   we/dst_addr/dst                 : registered register-file write port
//   fifo_cnt                        : LSU FIFO occupancy
// The ALU always has priority except when it has written STARVE_MAX times
// in a row with LSU results waiting; then it is stalled for one cycle so
// the FIFO head can drain. Writes to register 0 are dropped at acceptance.
module wb_arb
  import wb_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_vld,
  input  logic [4:0]             alu_addr,
  input  logic [31:0]            alu_data,
  output logic                   alu_stall,
  input  logic                   lsu_vld,
  output logic                   lsu_rdy,
  input  logic [4:0]             lsu_addr,
  input  logic [31:0]            lsu_data,
  output logic                   we,
  output logic [4:0]             dst_addr,
  output logic [31:0]            dst,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    dstAddr_q, dstAddr_d;
  logic [31:0]   dst_q, dst_d;

  logic          fifoNonEmpty;
  logic          aluWrite;
  logic          fifoPop;
  logic          lsuPush;
  wb_entry_t     pushEntry;
  wb_entry_t     headEntry;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lsuPush),
    .pushEntry_i (pushEntry),
    .pop_i       (fifoPop),
    .head_o      (headEntry),
    .count_o     (fifo_cnt)
  );

  // Handshakes depend only on registered state (and reset), never on the
  // valid inputs, so producers see no combinational loop through us.
  assign fifoNonEmpty = (fifo_cnt != '0);
  assign lsu_rdy      = !rst && (fifo_cnt != FULL_CNT);
  assign alu_stall    = !rst && (starve_q == STARVE_LIM) && fifoNonEmpty;

  // The ALU takes the write port whenever it has a real write; the FIFO
  // drains in every other cycle. Popping uses the pre-push count, so an
  // entry pushed into an empty FIFO waits at least one cycle.
  assign aluWrite  = !rst && alu_vld && !alu_stall && (alu_addr != 5'd0);
  assign fifoPop   = !rst && fifoNonEmpty && !aluWrite;
  assign lsuPush   = lsu_vld && lsu_rdy && (lsu_addr != 5'd0);
  assign pushEntry = '{addr: lsu_addr, data: lsu_data};

  // Starvation counter only advances while LSU work is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (fifoPop || !fifoNonEmpty) begin
      starve_d = '0;
    end else if (aluWrite && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Write-port selection; address and data hold when nothing is written.
  always_comb begin
    we_d      = 1'b0;
    dstAddr_d = dstAddr_q;
    dst_d     = dst_q;
    if (aluWrite) begin
      we_d      = 1'b1;
      dstAddr_d = alu_addr;
      dst_d     = alu_data;
    end else if (fifoPop) begin
      we_d      = 1'b1;
      dstAddr_d = headEntry.addr;
      dst_d     = headEntry.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      we_q      <= 1'b0;
      dstAddr_q <= '0;
      dst_q     <= '0;
    end else begin
      starve_q  <= starve_d;
      we_q      <= we_d;
      dstAddr_q <= dstAddr_d;
      dst_q     <= dst_d;
    end
  end

  assign we       = we_q;
  assign dst_addr = dstAddr_q;
  assign dst      = dst_q;

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb -- self-checking bench for wb_arb. A queue-based reference
// model tracks pending LSU writes and the starvation count; directed
// scenarios are followed by randomized traffic with occasional resets.
module tb_wb_arb;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld, lsu_vld;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_stall, lsu_rdy, we;
  logic [4:0]  dst_addr;
  logic [31:0] dst;
  logic [2:0]  fifo_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  wb_entry_t   modelQ[$];
  int          modelStarve = 0;
  logic        expWe = 1'b0;
  logic [4:0]  expAddr = '0;
  logic [31:0] expDst = '0;
  logic        sawStall = 1'b0;
  logic        sawRdy = 1'b0;

  // Random-phase stimulus variables
  logic        rR, rAv, rLv;
  logic [4:0]  rAa, rLa;
  logic [31:0] rAd, rLd;

  wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_vld   (alu_vld),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .lsu_vld   (lsu_vld),
    .lsu_rdy   (lsu_rdy),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .we        (we),
    .dst_addr  (dst_addr),
    .dst       (dst),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs (called just after a falling edge), checks
  // the handshakes, advances the model, then checks the registered outputs
  // at the next falling edge.
  task automatic applyStimulus(input logic r, input logic av,
                               input logic [4:0] aa, input logic [31:0] ad,
                               input logic lv, input logic [4:0] la,
                               input logic [31:0] ld);
    logic mStall, mRdy, ea, popNow, pushNow;
    int sizeBefore;
    wb_entry_t e;
    rst = r; alu_vld = av; alu_addr = aa; alu_data = ad;
    lsu_vld = lv; lsu_addr = la; lsu_data = ld;
    #1;
    sizeBefore = modelQ.size();
    mStall = !r && (modelStarve == SMAX) && (sizeBefore != 0);
    mRdy   = !r && (sizeBefore != DEPTH);
    checkOutput("alu_stall", 32'(alu_stall), 32'(mStall));
    checkOutput("lsu_rdy", 32'(lsu_rdy), 32'(mRdy));
    sawStall = alu_stall;
    sawRdy   = lsu_rdy;
    if (r) begin
      modelQ.delete();
      modelStarve = 0;
      expWe = 1'b0; expAddr = '0; expDst = '0;
    end else begin
      ea      = av && !mStall && (aa != 5'd0);
      popNow  = (sizeBefore != 0) && !ea;
      pushNow = lv && mRdy && (la != 5'd0);
      if (ea) begin
        expWe = 1'b1; expAddr = aa; expDst = ad;
      end else if (popNow) begin
        e = modelQ.pop_front();
        expWe = 1'b1; expAddr = e.addr; expDst = e.data;
      end else begin
        expWe = 1'b0;
      end
      if (popNow || sizeBefore == 0) modelStarve = 0;
      else if (ea && modelStarve < SMAX) modelStarve++;
      if (pushNow) begin
        e.addr = la; e.data = ld;
        modelQ.push_back(e);
      end
    end
    @(negedge clk);
    checkOutput("we", 32'(we), 32'(expWe));
    checkOutput("dst_addr", 32'(dst_addr), 32'(expAddr));
    checkOutput("dst", dst, expDst);
    checkOutput("fifo_cnt", 32'(fifo_cnt), 32'(modelQ.size()));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; alu_vld = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_vld = 1'b0; lsu_addr = '0; lsu_data = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 5'd6, 32'h66);
    checkOutput("reset_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);

    // ALU-only write
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("alu_we", 32'(we), 32'd1);
    checkOutput("alu_addr", 32'(dst_addr), 32'd5);
    checkOutput("alu_data", dst, 32'hDEADBEEF);
    idleCycle();

    // LSU into idle port: pushed, then written one cycle later
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    checkOutput("lsu_cnt1", 32'(fifo_cnt), 32'd1);
    checkOutput("lsu_no_we", 32'(we), 32'd0);
    idleCycle();
    checkOutput("lsu_we", 32'(we), 32'd1);
    checkOutput("lsu_addr", 32'(dst_addr), 32'd7);
    checkOutput("lsu_data", dst, 32'h1234);

    // Starvation: one LSU entry waits behind continuous ALU traffic
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA0, 1'b1, 5'd9, 32'hBEEF);
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hA0 + 32'(i), 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA4, 1'b0, 5'd0, 32'd0);
    checkOutput("starve_stall", 32'(sawStall), 32'd1);
    checkOutput("starve_lsu_addr", 32'(dst_addr), 32'd9);
    checkOutput("starve_lsu_data", dst, 32'hBEEF);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA4, 1'b0, 5'd0, 32'd0);
    checkOutput("starve_resume", dst, 32'hA4);
    idleCycle();

    // Full FIFO while the ALU is busy
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hB0 + 32'(i),
                    1'b1, 5'(10 + i), 32'hC0 + 32'(i));
    checkOutput("full_cnt", 32'(fifo_cnt), 32'd4);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hB4, 1'b1, 5'd14, 32'hC4);
    checkOutput("full_rdy_low", 32'(sawRdy), 32'd0);
    checkOutput("full_after_pop", 32'(fifo_cnt), 32'd3);
    checkOutput("full_rdy_back", 32'(lsu_rdy), 32'd1);
    checkOutput("full_pop_addr", 32'(dst_addr), 32'd10);

    // Reset with entries pending: nothing stale may come out afterwards
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("rst_mid_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("rst_mid_we", 32'(we), 32'd0);
    checkOutput("rst_mid_dst", dst, 32'd0);
    for (int i = 0; i < 4; i++) idleCycle();
    checkOutput("rst_no_stale", 32'(we), 32'd0);

    // Register 0 from both sources is discarded
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    checkOutput("r0_we", 32'(we), 32'd0);
    checkOutput("r0_cnt", 32'(fifo_cnt), 32'd0);

    // Randomized traffic; a stalled ALU producer holds its request
    rAv = 1'b0; rAa = '0; rAd = '0;
    for (int i = 0; i < 600; i++) begin
      rR = ($urandom_range(0, 63) == 0);
      if (!(sawStall && rAv)) begin
        rAv = ($urandom_range(0, 3) != 0);
        rAa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rAd = $urandom;
      end
      rLv = $urandom_range(0, 1) == 1;
      rLa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rLd = $urandom;
      applyStimulus(rR, rAv, rAa, rAd, rLv, rLa, rLd);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
